// File: rtl/disp_pkg.sv
// disp_pkg
//   Shared definitions for the display arbiter and the display driver:
//   the arbiter state encoding and the hold-time derivation that turns a
//   clock frequency and a hold duration in microseconds into clock cycles.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // no owner, display blanked
        LOCKED = 2'd1,  // owner granted, hold timer still running
        OWNED  = 2'd2   // owner granted, hold expired, may be pre-empted
    } arb_state_t;

    // Hold duration in clock cycles. Evaluated in 64 bits because
    // FREQ*HOLD_US overflows 32 bits for realistic values (27 MHz * 0.5 s).
    // Clamped to 1 so the hold timer always has at least one state.
    function automatic int hold_cycles(input longint freq_hz, input longint hold_us);
        longint cycles;
        cycles = (freq_hz * hold_us) / 64'sd1_000_000;
        if (cycles < 64'sd1) begin
            cycles = 64'sd1;
        end
        return int'(cycles);
    endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. Scans the request vector starting at
//   i_ptr, wrapping modulo N, skipping clients set in i_excl, and returns the
//   first hit as a one-hot vector.
//
//   i_req   [N-1:0]   request vector
//   i_ptr   [PW-1:0]  index where the search starts (0..N-1)
//   i_excl  [N-1:0]   clients that must not win (e.g. the current owner)
//   o_grant [N-1:0]   one-hot winner, all-zero when nobody qualifies
//   o_valid           a winner was found
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic [N-1:0]  i_excl,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    int            pos;
    logic [PW-1:0] idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(i_ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PW'(pos);
            if (!o_valid && i_req[idx] && !i_excl[idx]) begin
                o_grant[idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Arbitrates ownership of a shared multiplexed digit display between
//   REQUESTERS clients. A new owner is protected for HOLD cycles (LOCKED);
//   after that (OWNED) any other requesting client takes the display over
//   in round-robin order. The owner may refresh the image with i_wr and
//   releases the display by dropping i_req.
//
//   i_clk      clock, all state changes on rising edge
//   i_rst      asynchronous active-high reset
//   i_req      level request per client
//   i_data     digit image per client, client k at [k*DIGITS*4 +: DIGITS*4]
//   i_wr       one-cycle update strobe per client (only the owner's counts)
//   o_grant    one-hot current owner, zero when idle
//   o_digits   registered digit image for the display driver
//   o_blank    high when no client owns the display
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int REQUESTERS = 2,
    parameter int FREQ       = 27_000_000,
    parameter int HOLD_US    = 500_000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [REQUESTERS-1:0]            i_req,
    input  logic [REQUESTERS*DIGITS*4-1:0]   i_data,
    input  logic [REQUESTERS-1:0]            i_wr,
    output logic [REQUESTERS-1:0]            o_grant,
    output logic [DIGITS*4-1:0]              o_digits,
    output logic                             o_blank
);

    localparam int DW   = DIGITS * 4;
    localparam int HOLD = hold_cycles(longint'(FREQ), longint'(HOLD_US));
    localparam int TW   = $clog2(HOLD) + 1;
    localparam int PW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);

    arb_state_t              state_q, state_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [DW-1:0]           digits_q, digits_d;
    logic                    blank_q, blank_d;
    logic [TW-1:0]           timer_q, timer_d, timer_inc;
    logic [PW-1:0]           ptr_q, ptr_d;

    logic [REQUESTERS-1:0]   pick_grant;
    logic                    pick_valid;
    logic [PW-1:0]           win_idx, own_idx, win_ptr_next;
    logic                    owner_req, owner_wr, do_take;
    logic [DW-1:0]           client_data [REQUESTERS];

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_split
            assign client_data[gi] = i_data[gi*DW +: DW];
        end
    endgenerate

    // Excluding the current owner serves both cases: in IDLE grant_q is
    // zero so nothing is excluded; when owned, only challengers qualify.
    rr_pick #(
        .N  (REQUESTERS),
        .PW (PW)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .i_excl  (grant_q),
        .o_grant (pick_grant),
        .o_valid (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        own_idx = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (pick_grant[k]) begin
                win_idx = PW'(k);
            end
            if (grant_q[k]) begin
                own_idx = PW'(k);
            end
        end
        win_ptr_next = (win_idx == PW'(REQUESTERS - 1)) ? '0 : win_idx + PW'(1);
        owner_req    = |(i_req & grant_q);
        owner_wr     = |(i_wr & grant_q);
        // Saturating increment: the timer parks at HOLD-1 until reloaded.
        timer_inc    = (timer_q == HOLD_LAST) ? timer_q : timer_q + TW'(1);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        digits_d = digits_q;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        do_take  = 1'b0;

        case (state_q)
            IDLE: begin
                do_take = pick_valid;
            end
            LOCKED, OWNED: begin
                if (!owner_req) begin
                    // Release wins over a same-cycle owner write.
                    if (pick_valid) begin
                        do_take = 1'b1;
                    end else begin
                        grant_d = '0;
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end else if (state_q == OWNED && pick_valid) begin
                    do_take = 1'b1;
                end else begin
                    if (owner_wr) begin
                        digits_d = client_data[own_idx];
                    end
                    if (state_q == LOCKED) begin
                        timer_d = timer_inc;
                        // Leaving LOCKED as the timer lands on HOLD-1 lets a
                        // challenger take over exactly HOLD edges after grant.
                        if (timer_inc == HOLD_LAST) begin
                            state_d = OWNED;
                        end
                    end
                end
            end
            default: begin
                grant_d = '0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        if (do_take) begin
            grant_d  = pick_grant;
            digits_d = client_data[win_idx];
            timer_d  = '0;
            ptr_d    = win_ptr_next;
            state_d  = LOCKED;
        end

        blank_d = ~|grant_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            digits_q <= '0;
            blank_q  <= 1'b1;
            timer_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
        end
    end

    assign o_grant  = grant_q;
    assign o_digits = digits_q;
    assign o_blank  = blank_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter
//   Directed scenarios followed by a randomized phase, every step checked
//   against a behavioural model of the arbitration rules (owner, age since
//   grant, round-robin pointer as plain integers).
module tb_disp_arbiter;

    localparam int N    = 2;
    localparam int DW   = 16;
    localparam int HOLD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      wr;
    logic [N-1:0]      grant;
    logic [DW-1:0]     digits;
    logic              blank;

    always #5 clk = ~clk;

    disp_arbiter #(
        .DIGITS     (4),
        .REQUESTERS (N),
        .FREQ       (1_000_000),
        .HOLD_US    (8)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_data   (data),
        .i_wr     (wr),
        .o_grant  (grant),
        .o_digits (digits),
        .o_blank  (blank)
    );

    // Reference model state
    int            m_owner;   // -1 when idle
    int            m_ptr;
    int            m_age;     // edges since the current grant
    logic [DW-1:0] m_digits;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int rr_find(input int ptr, input logic [N-1:0] r, input int excl);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_age    = 0;
        m_digits = '0;
    endtask

    task automatic model_take(input int w);
        m_owner  = w;
        m_digits = data[w*DW +: DW];
        m_age    = 0;
        m_ptr    = (w + 1) % N;
    endtask

    task automatic model_edge();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            w = rr_find(m_ptr, req, -1);
            if (w >= 0) model_take(w);
        end else begin
            m_age++;
            w = rr_find(m_ptr, req, m_owner);
            if (!req[m_owner]) begin
                if (w >= 0) model_take(w);
                else m_owner = -1;
            end else if (m_age >= HOLD && w >= 0) begin
                model_take(w);
            end else if (wr[m_owner]) begin
                m_digits = data[m_owner*DW +: DW];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk({tag, ".grant"},  32'(grant),  32'(eg));
        chk({tag, ".digits"}, 32'(digits), 32'(m_digits));
        chk({tag, ".blank"},  32'(blank),  32'(m_owner < 0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        wr   = '0;
        data = '0;
        model_reset();

        // Reset state
        step("reset");
        chk("reset.grant_const", 32'(grant), 32'h0);
        chk("reset.blank_const", 32'(blank), 32'h1);
        rst = 1'b0;

        // Single request from idle: granted after one edge
        req  = 2'b01;
        data = {16'h0000, 16'h1234};
        step("r029");
        chk("r029.grant_const",  32'(grant),  32'h1);
        chk("r029.digits_const", 32'(digits), 32'h1234);

        // Contention during LOCKED: switch exactly HOLD edges after grant
        req  = 2'b11;
        data = {16'h5678, 16'h1234};
        for (int i = 1; i < HOLD; i++) begin
            step("r030.locked");
            chk("r030.hold_grant", 32'(grant), 32'h1);
        end
        step("r030.switch");
        chk("r030.switch_grant",  32'(grant),  32'h2);
        chk("r030.switch_digits", 32'(digits), 32'h5678);

        // Client1 alone until its hold has expired
        req = 2'b10;
        for (int i = 0; i < HOLD + 1; i++) step("r031.wait");
        wr   = 2'b01;
        data = {16'h5678, 16'hAAAA};
        step("r031.nonowner_wr");
        chk("r031.ignored", 32'(digits), 32'h5678);
        wr   = 2'b10;
        data = {16'hBEEF, 16'hAAAA};
        step("r031.owner_wr");
        chk("r031.beef", 32'(digits), 32'hBEEF);
        wr = 2'b00;
        step("r031.after");

        // Release in OWNED with no other request
        req = 2'b00;
        step("r032.release_owned");
        chk("r032.blank_owned", 32'(blank), 32'h1);

        // Release in LOCKED with no other request: image retained
        req = 2'b01;
        step("r032.grant0");
        step("r032.locked");
        req = 2'b00;
        step("r032.release_locked");
        chk("r032.idle_grant",  32'(grant),  32'h0);
        chk("r032.idle_digits", 32'(digits), 32'hAAAA);

        // Release with a waiting challenger: direct hand-over
        req = 2'b10;
        step("r032.grant1");
        req = 2'b11;
        step("r032.locked1");
        req = 2'b01;
        step("r032.handover");
        chk("r032.handover_grant", 32'(grant), 32'h1);
        chk("r032.handover_blank", 32'(blank), 32'h0);

        // Asynchronous reset mid-LOCKED, checked before the next edge
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("r034.grant",  32'(grant),  32'h0);
        chk("r034.digits", 32'(digits), 32'h0);
        chk("r034.blank",  32'(blank),  32'h1);
        #1;
        rst = 1'b0;

        // Simultaneous requests: client0 first, then round-robin to client1
        req = 2'b11;
        step("r033.first");
        chk("r033.first_grant", 32'(grant), 32'h1);
        req = 2'b00;
        step("r033.release");
        req = 2'b11;
        step("r033.second");
        chk("r033.second_grant", 32'(grant), 32'h2);

        // Randomized phase
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N; k++) req[k] = ($urandom_range(0, 9) < 8);
            wr   = 2'($urandom);
            data = $urandom;
            rst  = ($urandom_range(0, 99) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit digits on the shared multiplexed display.
REQ-002 Parameter REQUESTERS, default 2: number of clients competing for the display (2..8).
REQ-003 Parameters FREQ (default 27_000_000) and HOLD_US (default 500_000); derived integer HOLD = FREQ*HOLD_US/1_000_000 cycles, HOLD >= 1.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  REQUESTERS  level request per client; held high while the client wants the display.
REQ-007 i_data  input  REQUESTERS*DIGITS*4  digit image per client; client k occupies bits [k*DIGITS*4 +: DIGITS*4].
REQ-008 i_wr  input  REQUESTERS  one-cycle update strobe per client.
REQ-009 o_grant  output  REQUESTERS  one-hot current owner; all-zero when no owner.
REQ-010 o_digits  output  DIGITS*4  registered digit image driving the display driver's digit input.
REQ-011 o_blank  output  1  high when no client owns the display.

Function
REQ-012 States: IDLE (no owner), LOCKED (owner, hold timer running), OWNED (owner, hold expired).
REQ-013 Round-robin pointer: search starts at pointer, wraps modulo REQUESTERS, and is set to winner+1 (mod REQUESTERS) on every grant.
REQ-014 IDLE: with any i_req bit high, the winner is granted on the next edge; o_grant is one-hot, o_digits loads the winner's i_data, o_blank=0, timer=0, state goes to LOCKED (1-cycle req-to-grant latency).
REQ-015 LOCKED: timer increments each cycle; at timer==HOLD-1 the state goes to OWNED; requests from non-owners are ignored.
REQ-016 OWNED: with any non-owner i_req high, the grant moves directly to the round-robin winner among non-owners in one edge (no IDLE gap); o_digits loads the new owner's data, timer=0, state goes to LOCKED.
REQ-017 OWNED: with no competing request, the owner keeps the grant indefinitely.
REQ-018 In LOCKED or OWNED, an owner i_wr pulse loads the owner's i_data into o_digits on the next edge.
REQ-019 Non-owner i_wr pulses are ignored in every state.
REQ-020 Owner i_req low in any owned state releases on the next edge: if another i_req is high, the grant goes directly to the round-robin winner excluding the releasing client (per REQ-016 loading); otherwise o_grant=0, o_blank=1, state goes to IDLE.
REQ-021 In IDLE, o_digits retains the last image; it is never cleared except by reset.
REQ-022 Owner release has priority over owner i_wr in the same cycle; the write is dropped.
REQ-023 Timer width is $clog2(HOLD)+1 bits; it never wraps, saturating at HOLD-1 until it is reloaded.

Reset
REQ-024 While i_rst is high: state=IDLE, o_grant=0, o_digits=0, o_blank=1, timer=0, pointer=0, independent of i_clk.
REQ-025 Reset asserted mid-ownership aborts immediately; after deassertion, arbitration restarts from pointer 0.

Structure
REQ-026 Shared package disp_pkg holds the state encoding (IDLE/LOCKED/OWNED) and the HOLD derivation function, shared with the display driver's timing constants.
REQ-027 One combinational sub-module rr_pick (request vector, pointer, exclude mask -> one-hot winner, valid) implements the round-robin search.
REQ-028 All outputs are driven directly from registers.

Verification (bench: REQUESTERS=2, DIGITS=4, FREQ=1_000_000, HOLD_US=8 -> HOLD=8)
REQ-029 Reset, then i_req=01 with client0 data 0x1234 -> after 1 edge o_grant=01, o_digits=0x1234, o_blank=0.
REQ-030 Client0 owns; i_req=11 from cycle 1 -> o_grant stays 01 through LOCKED, switches to 10 with client1's data exactly 8 cycles after the grant.
REQ-031 Client1 owns in OWNED; i_wr[0] pulses (ignored), then i_wr[1] pulses with data 0xBEEF -> o_digits=0xBEEF one edge after the i_wr[1] pulse only.
REQ-032 Owner drops i_req during LOCKED with no other request -> next edge o_grant=00, o_blank=1, o_digits unchanged; owner drops i_req with the other client requesting -> grant moves directly.
REQ-033 Both request simultaneously from IDLE after reset -> client0 wins; after a release and re-request by both -> client1 wins (round-robin).
REQ-034 i_rst pulsed asynchronously mid-LOCKED -> outputs reach reset values before the next clock edge.
